// File: rtl/mpc_bound_vector_streamer.sv
// Streams a PERIOD-entry per-lane bound pattern REPEAT times as one valid/ready stream with index/last sideband.
// Optional macro MPC_BOUND_WRITE_EN adds a table write port (tbl_we/tbl_addr/tbl_wdata), honoured only while idle.
module mpc_bound_vector_streamer #(
    parameter int DataWidth = 18,
    parameter int LANES     = 1,
    parameter int PERIOD    = 2,
    parameter int REPEAT    = 3,
    parameter logic [PERIOD*LANES*DataWidth-1:0] INIT_VALUES = {18'h26DE0, 18'h38000},
    localparam int IW = (PERIOD*REPEAT > 1) ? $clog2(PERIOD*REPEAT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DataWidth-1:0] out_data,
    output logic [IW-1:0]              out_index,
    output logic                       out_last
`ifdef MPC_BOUND_WRITE_EN
    ,
    input  logic                       tbl_we,
    input  logic [((PERIOD*LANES > 1) ? $clog2(PERIOD*LANES) : 1)-1:0] tbl_addr,
    input  logic [DataWidth-1:0]       tbl_wdata
`endif
);

    localparam int N  = PERIOD*REPEAT;
    localparam int AW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int TW = PERIOD*LANES*DataWidth;
    localparam int LW = LANES*DataWidth;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t          state_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [AW-1:0]   addr_reg;
    logic [RW-1:0]   rep_reg;
    logic [IW-1:0]   idx_reg;

    // Data stage of the registered table read.
    logic            rd_valid_reg;
    logic [LW-1:0]   rd_data_reg;
    logic [IW-1:0]   rd_index_reg;
    logic            rd_last_reg;

    // Two-entry output buffer: out_* is the head, skid_* the second slot.
    logic [1:0]      count_reg;
    logic            out_valid_reg;
    logic [LW-1:0]   out_data_reg;
    logic [IW-1:0]   out_index_reg;
    logic            out_last_reg;
    logic [LW-1:0]   skid_data_reg;
    logic [IW-1:0]   skid_index_reg;
    logic            skid_last_reg;

    logic            pop;
    logic            issue;
    logic            last_issue;
    logic [2:0]      pending;
    logic [LW-1:0]   rd_word;

`ifdef MPC_BOUND_WRITE_EN
    logic [TW-1:0]   bound_tbl = INIT_VALUES;

    // Out-of-range addresses fall outside the vector and are discarded.
    always_ff @(posedge clk) begin
        if (tbl_we && !busy_reg)
            bound_tbl[int'(tbl_addr)*DataWidth +: DataWidth] <= tbl_wdata;
    end
`else
    logic [TW-1:0]   bound_tbl;
    assign bound_tbl = INIT_VALUES;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_word[gi*DataWidth +: DataWidth] =
            bound_tbl[(int'(addr_reg)*LANES + gi)*DataWidth +: DataWidth];
    end

    always_ff @(posedge clk) begin
        if (issue)
            rd_data_reg <= rd_word;
    end

    // Occupancy after this cycle's pop lets a read issue every cycle under full throughput.
    always_comb begin
        pop        = out_valid_reg & out_ready;
        pending    = 3'(count_reg) + 3'(rd_valid_reg) - 3'(pop);
        issue      = (state_reg == ST_RUN) && (pending < 3'd2);
        last_issue = (addr_reg == AW'(PERIOD-1)) && (rep_reg == RW'(REPEAT-1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            rep_reg        <= '0;
            idx_reg        <= '0;
            rd_valid_reg   <= 1'b0;
            rd_index_reg   <= '0;
            rd_last_reg    <= 1'b0;
            count_reg      <= 2'd0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_index_reg  <= '0;
            out_last_reg   <= 1'b0;
            skid_data_reg  <= '0;
            skid_index_reg <= '0;
            skid_last_reg  <= 1'b0;
        end else if (abort && state_reg != ST_IDLE) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            rep_reg        <= '0;
            idx_reg        <= '0;
            rd_valid_reg   <= 1'b0;
            rd_index_reg   <= '0;
            rd_last_reg    <= 1'b0;
            count_reg      <= 2'd0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_index_reg  <= '0;
            out_last_reg   <= 1'b0;
            skid_data_reg  <= '0;
            skid_index_reg <= '0;
            skid_last_reg  <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            rd_valid_reg <= issue;

            if (issue) begin
                rd_index_reg <= idx_reg;
                rd_last_reg  <= last_issue;
                idx_reg      <= idx_reg + IW'(1);
                if (addr_reg == AW'(PERIOD-1)) begin
                    addr_reg <= '0;
                    rep_reg  <= rep_reg + RW'(1);
                end else begin
                    addr_reg <= addr_reg + AW'(1);
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                        addr_reg  <= '0;
                        rep_reg   <= '0;
                        idx_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && last_issue)
                        state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && out_last_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            case (count_reg)
                2'd0: begin
                    if (rd_valid_reg) begin
                        out_data_reg  <= rd_data_reg;
                        out_index_reg <= rd_index_reg;
                        out_last_reg  <= rd_last_reg;
                        out_valid_reg <= 1'b1;
                        count_reg     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rd_valid_reg && pop) begin
                        out_data_reg  <= rd_data_reg;
                        out_index_reg <= rd_index_reg;
                        out_last_reg  <= rd_last_reg;
                    end else if (rd_valid_reg) begin
                        skid_data_reg  <= rd_data_reg;
                        skid_index_reg <= rd_index_reg;
                        skid_last_reg  <= rd_last_reg;
                        count_reg      <= 2'd2;
                    end else if (pop) begin
                        out_valid_reg <= 1'b0;
                        count_reg     <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_data_reg  <= skid_data_reg;
                        out_index_reg <= skid_index_reg;
                        out_last_reg  <= skid_last_reg;
                        if (rd_valid_reg) begin
                            skid_data_reg  <= rd_data_reg;
                            skid_index_reg <= rd_index_reg;
                            skid_last_reg  <= rd_last_reg;
                        end else begin
                            count_reg <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_index = out_index_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_mpc_bound_vector_streamer.sv
// Bench for mpc_bound_vector_streamer: cycle vector table, model-checked random backpressure runs, abort/reset corners.
module tb_mpc_bound_vector_streamer;

    logic        clk = 1'b0;
    logic        reset, start, abort, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [17:0] out_data;
    logic [2:0]  out_index;

    logic        start2, abort2, out_ready2;
    logic        busy2, done2, out_valid2, out_last2;
    logic [35:0] out_data2;
    logic [2:0]  out_index2;

`ifdef MPC_BOUND_WRITE_EN
    logic        tbl_we;
    logic [0:0]  tbl_addr;
    logic [17:0] tbl_wdata;
`endif

    int checks = 0;
    int errors = 0;

    logic [17:0] mtab [2];

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [17:0] data;
        logic [2:0]  index;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    mpc_bound_vector_streamer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last)
`ifdef MPC_BOUND_WRITE_EN
        , .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
`endif
    );

    mpc_bound_vector_streamer #(
        .DataWidth(18), .LANES(2), .PERIOD(3), .REPEAT(2),
        .INIT_VALUES({18'h06666, 18'h05555, 18'h04444, 18'h03333, 18'h02222, 18'h01111})
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_index(out_index2), .out_last(out_last2)
`ifdef MPC_BOUND_WRITE_EN
        , .tbl_we(1'b0), .tbl_addr(3'd0), .tbl_wdata(18'd0)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic st, input logic rdy, input logic v, input logic [17:0] d,
                           input logic [2:0] ix, input logic l, input logic b, input logic dn);
        vec_t t;
        t.start = st; t.ready = rdy; t.valid = v; t.data = d;
        t.index = ix; t.last = l; t.busy = b; t.done = dn;
        vq.push_back(t);
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        logic [5:0] p;
        p = 6'b101001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return p[c % 6];
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One full run on dut, every handshake compared with the pattern table model.
    task automatic run_check(input int mode, input bit wr_busy);
        int k; bit seen_done; bit pstall; logic rdy;
        logic [17:0] pd; logic [2:0] pix; logic pl;
        k = 0; seen_done = 0; pstall = 0; pd = '0; pix = '0; pl = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (done) begin
                chk("done_after_last_beat", 64'(k), 64'(6));
                chk("busy_low_at_done", 64'(busy), 64'(0));
                seen_done = 1;
            end else begin
                if (pstall) begin
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_data", 64'(out_data), 64'(pd));
                    chk("stall_index", 64'(out_index), 64'(pix));
                    chk("stall_last", 64'(out_last), 64'(pl));
                end
                rdy = pick_ready(mode, c);
                out_ready = rdy;
                if (out_valid) begin
                    pstall = !rdy; pd = out_data; pix = out_index; pl = out_last;
                    if (rdy) begin
                        chk("beat_data", 64'(out_data), 64'(mtab[k % 2]));
                        chk("beat_index", 64'(out_index), 64'(k));
                        chk("beat_last", 64'(out_last), 64'(k == 5));
                        k++;
                    end
                end else begin
                    pstall = 0;
                end
`ifdef MPC_BOUND_WRITE_EN
                tbl_we = 1'b0;
                if (wr_busy && k == 2 && out_valid && !rdy) begin
                    tbl_we = 1'b1; tbl_addr = 1'b0; tbl_wdata = 18'h12345;
                end else if (wr_busy && k == 2 && !out_valid) begin
                    tbl_we = 1'b1; tbl_addr = 1'b0; tbl_wdata = 18'h12345;
                end
`endif
                @(negedge clk);
            end
        end
`ifdef MPC_BOUND_WRITE_EN
        tbl_we = 1'b0;
`endif
        if (!seen_done) begin
            chk("stream_timeout", 64'(0), 64'(1));
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'(0));
        end
        if (wr_busy) chk("busy_write_tested_in_run", 64'(k), 64'(6));
    endtask

    task automatic run_dut2();
        int k; bit seen_done; logic rdy; logic [17:0] e0, e1;
        k = 0; seen_done = 0;
        start2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (done2) begin
                chk("l2_done_after_last", 64'(k), 64'(6));
                chk("l2_busy_at_done", 64'(busy2), 64'(0));
                seen_done = 1;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
                out_ready2 = rdy;
                if (out_valid2 && rdy) begin
                    e0 = 18'((2*(k % 3) + 1) * 32'h1111);
                    e1 = 18'((2*(k % 3) + 2) * 32'h1111);
                    chk("l2_lane0", 64'(out_data2[17:0]), 64'(e0));
                    chk("l2_lane1", 64'(out_data2[35:18]), 64'(e1));
                    chk("l2_index", 64'(out_index2), 64'(k));
                    chk("l2_last", 64'(out_last2), 64'(k == 5));
                    k++;
                end
                @(negedge clk);
            end
        end
        if (!seen_done) chk("l2_timeout", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit aborted, found;
        int k;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b0;
`ifdef MPC_BOUND_WRITE_EN
        tbl_we = 1'b0; tbl_addr = 1'b0; tbl_wdata = '0;
`endif
        mtab[0] = 18'h38000;
        mtab[1] = 18'h26DE0;

        // start, ready, valid, data, index, last, busy, done (state after each posedge)
        add_vec(1'b1, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd1, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd2, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd3, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd4, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd5, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd1, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd2, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd3, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h38000, 3'd4, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b1, 18'h26DE0, 3'd5, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 18'h0,     3'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_data", 64'(out_data), 64'(0));
        chk("reset_index", 64'(out_index), 64'(0));
        chk("reset_last", 64'(out_last), 64'(0));
        reset = 1'b0;

        foreach (vq[i]) begin
            start = vq[i].start;
            out_ready = vq[i].ready;
            @(negedge clk);
            chk($sformatf("tv%0d_valid", i), 64'(out_valid), 64'(vq[i].valid));
            chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(vq[i].busy));
            chk($sformatf("tv%0d_done", i), 64'(done), 64'(vq[i].done));
            if (vq[i].valid) begin
                chk($sformatf("tv%0d_data", i), 64'(out_data), 64'(vq[i].data));
                chk($sformatf("tv%0d_index", i), 64'(out_index), 64'(vq[i].index));
                chk($sformatf("tv%0d_last", i), 64'(out_last), 64'(vq[i].last));
            end
        end
        start = 1'b0;

        run_check(1, 1'b0);
        repeat (3) run_check(2, 1'b0);

        // Restart attempt at beat 2 must be ignored; abort at beat 3 flushes with no done.
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; aborted = 0;
        for (int c = 0; c < 50 && !aborted; c++) begin
            if (out_valid) begin
                chk("ab_index", 64'(out_index), 64'(k));
                if (k == 3) begin
                    abort = 1'b1; aborted = 1;
                end else begin
                    if (k == 2) start = 1'b1;
                    k++;
                end
            end
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
        end
        chk("ab_reached", 64'(aborted), 64'(1));
        chk("ab_valid", 64'(out_valid), 64'(0));
        chk("ab_busy", 64'(busy), 64'(0));
        chk("ab_done", 64'(done), 64'(0));
        @(negedge clk);
        chk("ab_done_later", 64'(done), 64'(0));
        chk("ab_busy_later", 64'(busy), 64'(0));
        run_check(0, 1'b0);

        // Asynchronous reset between clock edges mid-stream.
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (out_valid && out_index == 3'd2) found = 1;
            else @(negedge clk);
        end
        chk("rst_reached", 64'(found), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_index", 64'(out_index), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_no_done", 64'(done), 64'(0));
        run_check(0, 1'b0);

        run_dut2();
        run_dut2();

`ifdef MPC_BOUND_WRITE_EN
        tbl_we = 1'b1; tbl_addr = 1'b1; tbl_wdata = 18'h3FFFF;
        @(negedge clk);
        tbl_we = 1'b0;
        mtab[1] = 18'h3FFFF;
        run_check(0, 1'b0);
        run_check(2, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpc_bound_vector_streamer.md
Name: mpc_bound_vector_streamer

Overview:
- Parametrised successor to the single-port constraint-bound ROMs in the MPC dense-constraint pipeline.
- Holds a PERIOD-entry bound pattern per lane and streams it REPEAT times (the prediction horizon) as one valid/ready stream of PERIOD*REPEAT beats.
- Supports multiple packed lanes, backpressure, abort and an index/last sideband.
- Feeds the vsub/constraint datapath without HLS-side address generation.

Parameters:
- DataWidth, 18, bits per lane element (two's-complement fixed point).
- LANES, 1, number of parallel bound lanes packed in out_data.
- PERIOD, 2, entries per lane in the pattern table (>=1).
- REPEAT, 3, pattern repetitions per run (>=1).
- INIT_VALUES, {18'h26DE0,18'h38000}, PERIOD*LANES*DataWidth packed init. Entry e of lane l sits at bits [(e*LANES+l)*DataWidth +: DataWidth].
- Derived, not overridable:
  - AW = max(1, clog2(PERIOD)).
  - IW = max(1, clog2(PERIOD*REPEAT)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a run; accepted only in IDLE.
- abort  in  1  synchronous flush of current run.
- busy  out  1  high from the cycle after accepted start until stream ends or is aborted.
- done  out  1  one-cycle pulse after final beat handshake.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts beat.
- out_data  out  LANES*DataWidth  lane l at [l*DataWidth +: DataWidth].
- out_index  out  IW  beat number 0..PERIOD*REPEAT-1.
- out_last  out  1  high on final beat.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. busy, done, out_valid, out_last = 0. out_data, out_index = 0. Counters = 0. Table contents are not altered by reset.
- State machine IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start=1 loads addr=0, rep=0, idx=0, then moves to RUN. busy rises the next cycle.
  - RUN: issues one table read per cycle while the pipeline has space. addr wraps PERIOD-1 -> 0 and increments rep. After read PERIOD*REPEAT-1 is issued, moves to DRAIN.
  - DRAIN: waits until every issued beat has been handshaken. On the cycle the final beat (out_last) completes out_valid&out_ready, moves to IDLE and pulses done for exactly the next cycle; busy falls that same cycle.
- Read path: table read is registered, 1-cycle latency (address stage -> data stage). A 2-entry skid/output buffer guarantees:
  - Throughput of 1 beat/cycle when out_ready is held high. The first beat is valid 2 cycles after start is sampled.
  - No beat lost or duplicated under arbitrary out_ready. out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
  - Reads are issued only when buffer occupancy plus in-flight reads is < 2.
- out_index increments by exactly 1 per handshake. out_last = (out_index == PERIOD*REPEAT-1).
- start while busy: ignored, with no effect on counters.
- start in the same cycle as done: accepted, and a new run begins with no idle gap required.
- abort, with priority over start:
  - Next cycle: state=IDLE, buffer emptied, out_valid=0, busy=0, no done pulse, counters cleared.
  - abort in IDLE is a no-op.
- PERIOD=1: addr is constant 0 and every beat carries entry 0.
- REPEAT=1: stream length equals PERIOD.
- Asserting reset mid-run yields the reset values above immediately, with no done pulse.
- Data is passed verbatim; there is no arithmetic on table values.

Optional Feature:
- Macro MPC_BOUND_WRITE_EN.
- Defined: adds three ports:
  - tbl_we in 1.
  - tbl_addr in clog2(PERIOD*LANES).
  - tbl_wdata in DataWidth.
- Write semantics: a synchronous write to flat entry tbl_addr = e*LANES+l. Writes are honoured only when busy=0; a write while busy is dropped.
- A write in cycle t is visible to a run started at t+1 or later.
- Not defined: the ports are absent and the table is read-only, initialised from INIT_VALUES.

Test Plan:
- Defaults, out_ready=1, start pulse -> 6 beats on consecutive cycles: data 38000, 26DE0, 38000, 26DE0, 38000, 26DE0; out_index 0..5; out_last only on index 5; done one cycle after beat 5; first out_valid 2 cycles after start.
- Defaults, out_ready toggled 1,0,0,1,0,1... -> same 6-beat sequence, with no drops or duplicates; data held stable while stalled.
- LANES=2, PERIOD=3, REPEAT=2, distinct init values -> 6 beats, each with the correct lane pair; addr wraps 2 -> 0 at beat 3.
- start pulsed again at beat 2 -> ignored. abort at beat 3 -> out_valid=0 and busy=0 next cycle, no done. A new start then restarts at index 0.
- reset asserted asynchronously mid-stream (between clock edges) -> all outputs 0 immediately. After release, start runs a clean 6-beat stream.
- MPC_BOUND_WRITE_EN defined: while idle, write entry 1 = 3FFFF, then start -> beats alternate 38000, 3FFFF. A write attempted while busy leaves the stream unchanged.
